alu_control_mc: RTL
===================

Name: alu_control_mc

Overview:
- Next-generation EX-stage ALU control for the pipelined RISC-V core.
- Fully decodes {funct7, funct3} and ALUOp into a CTRL_W-bit ALU operation code, adding SLT, SRA and MUL support plus illegal-op detection.
- Sequences multi-cycle MUL: issues a start pulse to the multiplier and stalls the pipeline (stall_o) until the configured latency expires.
- Sits between the ID/EX pipeline register and the ALU/multiplier; stall_o feeds the hazard unit.

Parameters:
- MUL_CYCLES, 4, cycles a MUL occupies EX (legal range 1 to 16).
- CTRL_W, 4, width of ALUCtrl_o (minimum 4).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous and active-high.
- valid_i  input  1  EX holds a valid instruction.
- flush_i  input  1  pipeline flush; kills the EX instruction.
- funct_i  input  10  {funct7[6:0], funct3[2:0]}; funct_i[9:3]=funct7, funct_i[2:0]=funct3.
- ALUOp_i  input  2  00 load/store, 01 branch, 10 I-type ALU, 11 R-type.
- ALUCtrl_o  output  CTRL_W  operation code to the ALU.
- illegal_o  output  1  valid_i high with an undecodable op.
- start_o  output  1  one-cycle multiplier start pulse.
- stall_o  output  1  hold IF/ID/EX while a MUL is in progress.
- done_o  output  1  one-cycle pulse marking the multiplier result as valid.

Behaviour:
- Codes, zero-extended to CTRL_W: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, MUL=9, NOP=15.
- ALUOp 00 -> ADD; 01 -> SUB.
- ALUOp 11 (R-type):
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA.
  - funct7=0000001 with funct3 000: MUL.
  - Any other combination -> NOP with illegal_o=valid_i.
- ALUOp 10 (I-type):
  - funct3 000 ADD, 010 SLT, 100 XOR, 110 OR, 111 AND (funct7 ignored).
  - funct3 001: SLL only if funct7=0.
  - funct3 101: funct7=0 -> SRL; funct7=0100000 -> SRA.
  - Any other combination -> NOP/illegal.
- Decode is combinational, zero latency, in IDLE.
- FSM states: IDLE, BUSY.
- Counter: cnt, width 5, reset 0.
- Latched op register: op_q, reset ADD.
- IDLE transitions:
  - valid_i=1, decoded op MUL, flush_i=0: start_o=1 this cycle, op_q<=MUL.
  - If MUL_CYCLES>1: stall_o=1 this cycle, cnt<=MUL_CYCLES-2, next state BUSY.
  - If MUL_CYCLES=1: done_o=1 in the same cycle, stall_o=0, remain IDLE.
- BUSY:
  - ALUCtrl_o=op_q regardless of inputs; start_o=0.
  - cnt!=0: stall_o=1, cnt decrements.
  - cnt==0: stall_o=0, done_o=1, next state IDLE.
- Totals per MUL: stall_o high for exactly MUL_CYCLES-1 cycles; exactly one start_o and one done_o.
- Flush:
  - flush_i in BUSY: stall_o=0 and done_o=0 that cycle; next state IDLE; cnt<=0.
  - flush_i in IDLE: suppresses start_o, stall_o and done_o for that cycle; illegal_o is forced to 0.
- valid_i=0 in IDLE: no start and no stall; ALUCtrl_o still shows the decode.
- Back-to-back MULs: the cycle after BUSY->IDLE may start a new MUL; there are no idle bubbles between them.
- Reset (asynchronous, any state, including mid-MUL):
  - State returns to IDLE, cnt=0, op_q=ADD.
  - While rst_i=1: start_o=0, stall_o=0, done_o=0, illegal_o=0, ALUCtrl_o=0.
  - After release, first behaviour is IDLE decode.

Test Plan:
- ALUOp=11, valid_i=1, sweep funct_i over all ten R-type encodings -> ALUCtrl_o 0,1,2,3,4,5,6,7,8,9 as mapped; stall_o=0; illegal_o=0.
- ALUOp=10, funct_i=10'b0100000_101 -> SRA (7); funct_i=10'b0000001_001 -> NOP (15) with illegal_o=1; ALUOp=00 and 01 with random funct -> 0 and 1.
- MUL_CYCLES=4: ALUOp=11, funct_i=10'b0000001_000, valid_i=1 at cycle 0 -> start_o=1 at c0 only; stall_o=1 at c0..c2; done_o=1 at c3; ALUCtrl_o=9 throughout, even with funct_i randomised from c1.
- MUL_CYCLES=1 build: same MUL stimulus -> start_o=1 and done_o=1 in the same cycle; stall_o never asserted.
- MUL started at c0, flush_i=1 at c1 -> stall_o=0 at c1, done_o never asserted, state IDLE at c2; a second MUL at c2 restarts a full 3-cycle stall.
- MUL started at c0, rst_i asserted mid-cycle c1 (asynchronously) -> all outputs 0 immediately; after release no done_o appears.

Source files
------------

// File: rtl/alu_control_mc.sv
// alu_control_mc
// EX-stage ALU control for the pipelined RISC-V core.
// The {funct7, funct3} and ALUOp fields decode combinationally into an ALU
// operation code. Illegal combinations are flagged.
// A multi-cycle MUL is sequenced by a small IDLE/BUSY machine. The machine
// pulses start_o, holds the pipeline with stall_o, and pulses done_o when the
// multiplier result is valid.

module alu_control_mc #(
   parameter int MUL_CYCLES = 4,
   parameter int CTRL_W     = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic [9:0]        funct_i,
   input  logic [1:0]        ALUOp_i,
   output logic [CTRL_W-1:0] ALUCtrl_o,
   output logic              illegal_o,
   output logic              start_o,
   output logic              stall_o,
   output logic              done_o
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLL = 4'd5;
   localparam logic [3:0] OP_SRL = 4'd6;
   localparam logic [3:0] OP_SRA = 4'd7;
   localparam logic [3:0] OP_SLT = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam logic [3:0] OP_NOP = 4'd15;

   // A single-cycle multiplier never enters BUSY. Otherwise the counter is
   // loaded so that it reaches zero in the last BUSY cycle.
   localparam bit         MULTI    = (MUL_CYCLES > 1);
   localparam logic [4:0] CNT_LOAD = MULTI ? 5'(MUL_CYCLES - 2) : 5'd0;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [3:0] op_q, op_d;

   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [3:0] decOp;
   logic       decIllegal;
   logic [3:0] ctrlCode;

   assign funct7 = funct_i[9:3];
   assign funct3 = funct_i[2:0];

   // Combinational decode of ALUOp/funct into an operation code; anything unmapped becomes NOP
   always_comb begin
      decOp = OP_NOP;
      case (ALUOp_i)
         2'b00: decOp = OP_ADD;
         2'b01: decOp = OP_SUB;
         2'b10: begin
            case (funct3)
               3'b000: decOp = OP_ADD;
               3'b010: decOp = OP_SLT;
               3'b100: decOp = OP_XOR;
               3'b110: decOp = OP_OR;
               3'b111: decOp = OP_AND;
               3'b001: if (funct7 == 7'b0000000) decOp = OP_SLL;
               3'b101: begin
                  if (funct7 == 7'b0000000)
                     decOp = OP_SRL;
                  else if (funct7 == 7'b0100000)
                     decOp = OP_SRA;
               end
               default: decOp = OP_NOP;
            endcase
         end
         default: begin
            case (funct7)
               7'b0000000: begin
                  case (funct3)
                     3'b000:  decOp = OP_ADD;
                     3'b001:  decOp = OP_SLL;
                     3'b010:  decOp = OP_SLT;
                     3'b100:  decOp = OP_XOR;
                     3'b101:  decOp = OP_SRL;
                     3'b110:  decOp = OP_OR;
                     3'b111:  decOp = OP_AND;
                     default: decOp = OP_NOP;
                  endcase
               end
               7'b0100000: begin
                  if (funct3 == 3'b000)
                     decOp = OP_SUB;
                  else if (funct3 == 3'b101)
                     decOp = OP_SRA;
               end
               7'b0000001: if (funct3 == 3'b000) decOp = OP_MUL;
               default: decOp = OP_NOP;
            endcase
         end
      endcase
      decIllegal = (decOp == OP_NOP);
   end

   // State, countdown and latched-op registers; reset may land mid-MUL and abandons it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         op_q    <= OP_ADD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   // Next-state and handshake outputs; reset forces every output low immediately
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      ctrlCode  = decOp;
      illegal_o = 1'b0;
      start_o   = 1'b0;
      stall_o   = 1'b0;
      done_o    = 1'b0;
      case (state_q)
         IDLE: begin
            ctrlCode = decOp;
            if (!flush_i) begin
               illegal_o = valid_i & decIllegal;
               if (valid_i && (decOp == OP_MUL)) begin
                  start_o = 1'b1;
                  op_d    = OP_MUL;
                  if (MULTI) begin
                     stall_o = 1'b1;
                     cnt_d   = CNT_LOAD;
                     state_d = BUSY;
                  end else begin
                     done_o = 1'b1;
                  end
               end
            end
         end
         default: begin
            ctrlCode = op_q;
            if (flush_i) begin
               state_d = IDLE;
               cnt_d   = 5'd0;
            end else if (cnt_q != 5'd0) begin
               stall_o = 1'b1;
               cnt_d   = cnt_q - 5'd1;
            end else begin
               done_o  = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
      if (rst_i) begin
         ctrlCode  = 4'd0;
         illegal_o = 1'b0;
         start_o   = 1'b0;
         stall_o   = 1'b0;
         done_o    = 1'b0;
      end
   end

   assign ALUCtrl_o = CTRL_W'(ctrlCode);

endmodule
